// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the instruction sequencer: state encoding,
// opcode/ext field values, branch condition codes and flag bit positions.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_LOAD_WB = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_CMP,
        CL_MOV,
        CL_LOAD,
        CL_STOR,
        CL_JCND,
        CL_BCND,
        CL_HALT
    } instr_class_t;

    // Opcode field values (instr[15:12])
    localparam logic [3:0] OP_EXT  = 4'b0000;  // register-form ALU group
    localparam logic [3:0] OP_SPEC = 4'b0100;  // load/store/jump/halt group
    localparam logic [3:0] OP_CMPI = 4'b1011;
    localparam logic [3:0] OP_BCND = 4'b1100;
    localparam logic [3:0] OP_MOVI = 4'b1101;

    // Extended opcode field values (instr[7:4])
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_JCND = 4'b1100;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_HALT = 4'b1111;

    // Branch condition codes (instr[11:8])
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_UC = 4'b1110;

    // Flag register bit positions
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // Classify an instruction from its opcode and ext fields.
    function automatic instr_class_t decode_class(input logic [3:0] op,
                                                  input logic [3:0] ext);
        instr_class_t cls;
        cls = CL_ALU;
        if (op == OP_SPEC) begin
            case (ext)
                EXT_LOAD: cls = CL_LOAD;
                EXT_STOR: cls = CL_STOR;
                EXT_JCND: cls = CL_JCND;
                EXT_HALT: cls = CL_HALT;
                default:  cls = CL_ALU;
            endcase
        end else if (op == OP_BCND) begin
            cls = CL_BCND;
        end else if (op == OP_CMPI || (op == OP_EXT && ext == EXT_CMP)) begin
            cls = CL_CMP;
        end else if (op == OP_MOVI || (op == OP_EXT && ext == EXT_MOV)) begin
            cls = CL_MOV;
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_check.sv
// Branch condition evaluator: decides whether a conditional jump/branch is
// taken from the current flag register and the instruction's condition field.
module cond_check
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    // The L flag has no condition code of its own.
    logic unused_flag_l;
    assign unused_flag_l = flags[FLAG_L];

    // Map each condition code onto its flag test; unknown codes never branch.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken =  flags[FLAG_Z];
            CC_NE:   taken = ~flags[FLAG_Z];
            CC_CS:   taken =  flags[FLAG_C];
            CC_CC:   taken = ~flags[FLAG_C];
            CC_GT:   taken =  flags[FLAG_N];
            CC_LE:   taken = ~flags[FLAG_N];
            CC_FS:   taken =  flags[FLAG_F];
            CC_FC:   taken = ~flags[FLAG_F];
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH -> DECODE -> EXECUTE
// (-> LOAD_WB) and drives the datapath strobes combinationally from the
// current state and instruction.
module instr_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [4:0]  flags,
    input  logic        stall,
    output logic        pc_enable,
    output logic        pc_load,
    output logic        pc_rel,
    output logic        ir_enable,
    output logic        reg_we,
    output logic        flags_enable,
    output logic        alu_bus_sel,
    output logic        addr_sel,
    output logic        we_a,
    output logic        halted,
    output logic [2:0]  state
);

    state_t       cur_state;
    state_t       next_state;
    instr_class_t cls;
    logic         taken;

    // Rsrc selects a register inside the datapath; the sequencer never looks at it.
    logic unused_rsrc;
    assign unused_rsrc = ^instr[3:0];

    assign cls   = decode_class(instr[15:12], instr[7:4]);
    assign state = cur_state;

    cond_check u_cond_check (
        .flags (flags),
        .cond  (instr[11:8]),
        .taken (taken)
    );

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so the register samples pre-edge values
        // no matter how the simulator orders the always blocks.
        if (reset) cur_state <= ST_FETCH;
        else       cur_state <= next_state;
    end

    // Next-state selection; stall only holds the machine in FETCH.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can leave it
        // unassigned and infer a latch.
        next_state = cur_state;
        case (cur_state)
            ST_FETCH:   next_state = stall ? ST_FETCH : ST_DECODE;
            ST_DECODE:  next_state = ST_EXECUTE;
            ST_EXECUTE: begin
                case (cls)
                    CL_LOAD: next_state = ST_LOAD_WB;
                    CL_HALT: next_state = ST_HALT;
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_LOAD_WB: next_state = ST_FETCH;
            ST_HALT:    next_state = ST_HALT;
            default:    next_state = ST_FETCH;
        endcase
    end

    // Datapath strobes; reset forces all of them low so an aborted
    // instruction writes nothing.
    always_comb begin
        pc_enable    = 1'b0;
        pc_load      = 1'b0;
        pc_rel       = 1'b0;
        ir_enable    = 1'b0;
        reg_we       = 1'b0;
        flags_enable = 1'b0;
        alu_bus_sel  = 1'b1;
        addr_sel     = 1'b0;
        we_a         = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            case (cur_state)
                ST_DECODE: ir_enable = 1'b1;
                ST_EXECUTE: begin
                    case (cls)
                        CL_ALU: begin
                            reg_we       = 1'b1;
                            flags_enable = 1'b1;
                            pc_enable    = 1'b1;
                        end
                        CL_CMP: begin
                            flags_enable = 1'b1;
                            pc_enable    = 1'b1;
                        end
                        CL_MOV: begin
                            reg_we    = 1'b1;
                            pc_enable = 1'b1;
                        end
                        CL_LOAD: addr_sel = 1'b1;
                        CL_STOR: begin
                            addr_sel  = 1'b1;
                            we_a      = 1'b1;
                            pc_enable = 1'b1;
                        end
                        CL_JCND, CL_BCND: begin
                            if (taken) begin
                                pc_load = 1'b1;
                                pc_rel  = (cls == CL_BCND);
                            end else begin
                                pc_enable = 1'b1;
                            end
                        end
                        default: ;  // HALT: no strobes on the way in
                    endcase
                end
                ST_LOAD_WB: begin
                    addr_sel    = 1'b1;
                    alu_bus_sel = 1'b0;
                    reg_we      = 1'b1;
                    pc_enable   = 1'b1;
                end
                ST_HALT: halted = 1'b1;
                default: ;  // FETCH: address from PC, no strobes
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a vector table covering each
// instruction class and condition code, plus hand-written sequences for
// stall, reset mid-LOAD and HALT.
module tb_instr_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        stall;
    logic        pc_enable, pc_load, pc_rel, ir_enable, reg_we;
    logic        flags_enable, alu_bus_sel, addr_sel, we_a, halted;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    // Output bundle order: pc_enable pc_load pc_rel ir_enable reg_we
    //                      flags_enable alu_bus_sel addr_sel we_a halted
    logic [9:0] outs;
    assign outs = {pc_enable, pc_load, pc_rel, ir_enable, reg_we,
                   flags_enable, alu_bus_sel, addr_sel, we_a, halted};

    localparam logic [9:0] O_IDLE   = 10'b0000001000;
    localparam logic [9:0] O_DECODE = 10'b0001001000;
    localparam logic [9:0] O_ALU    = 10'b1000111000;
    localparam logic [9:0] O_CMP    = 10'b1000011000;
    localparam logic [9:0] O_MOV    = 10'b1000101000;
    localparam logic [9:0] O_STOR   = 10'b1000001110;
    localparam logic [9:0] O_LOAD   = 10'b0000001100;
    localparam logic [9:0] O_LOADWB = 10'b1000100100;
    localparam logic [9:0] O_BTAKE  = 10'b0110001000;
    localparam logic [9:0] O_JTAKE  = 10'b0100001000;
    localparam logic [9:0] O_NOTAKE = 10'b1000001000;
    localparam logic [9:0] O_HALT   = 10'b0000001001;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [9:0]  exp_exec;
        logic [2:0]  exp_next;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    instr_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .flags        (flags),
        .stall        (stall),
        .pc_enable    (pc_enable),
        .pc_load      (pc_load),
        .pc_rel       (pc_rel),
        .ir_enable    (ir_enable),
        .reg_we       (reg_we),
        .flags_enable (flags_enable),
        .alu_bus_sel  (alu_bus_sel),
        .addr_sel     (addr_sel),
        .we_a         (we_a),
        .halted       (halted),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_vec(input int i, input string name, input logic [15:0] ins,
                           input logic [4:0] fl, input logic [9:0] ex, input logic [2:0] nx);
        vecs[i].name     = name;
        vecs[i].instr    = ins;
        vecs[i].flags    = fl;
        vecs[i].exp_exec = ex;
        vecs[i].exp_next = nx;
    endtask

    initial begin
        reset = 1'b1;
        instr = 16'h0000;
        flags = 5'b00000;
        stall = 1'b0;

        set_vec( 0, "add",      16'h0152, 5'b00000, O_ALU,    ST_FETCH);
        set_vec( 1, "alu_op4",  16'h4010, 5'b00000, O_ALU,    ST_FETCH);
        set_vec( 2, "cmpi",     16'hB123, 5'b00000, O_CMP,    ST_FETCH);
        set_vec( 3, "cmp_ext",  16'h01B2, 5'b00000, O_CMP,    ST_FETCH);
        set_vec( 4, "movi",     16'hD120, 5'b00000, O_MOV,    ST_FETCH);
        set_vec( 5, "mov_ext",  16'h01D2, 5'b00000, O_MOV,    ST_FETCH);
        set_vec( 6, "stor",     16'h4143, 5'b00000, O_STOR,   ST_FETCH);
        set_vec( 7, "load",     16'h4203, 5'b00000, O_LOAD,   ST_LOAD_WB);
        set_vec( 8, "halt",     16'h40F0, 5'b00000, O_IDLE,   ST_HALT);
        set_vec( 9, "beq_z1",   16'hC005, 5'b01000, O_BTAKE,  ST_FETCH);
        set_vec(10, "beq_z0",   16'hC005, 5'b00000, O_NOTAKE, ST_FETCH);
        set_vec(11, "buc",      16'hCE10, 5'b00000, O_BTAKE,  ST_FETCH);
        set_vec(12, "jne_z0",   16'h41C2, 5'b00000, O_JTAKE,  ST_FETCH);
        set_vec(13, "jcs_c1",   16'h42C0, 5'b00001, O_JTAKE,  ST_FETCH);
        set_vec(14, "bcc_c1",   16'hC3F0, 5'b00001, O_NOTAKE, ST_FETCH);
        set_vec(15, "bgt_n1",   16'hC604, 5'b10000, O_BTAKE,  ST_FETCH);
        set_vec(16, "ble_n1",   16'hC704, 5'b10000, O_NOTAKE, ST_FETCH);
        set_vec(17, "bfs_f1",   16'hC801, 5'b00100, O_BTAKE,  ST_FETCH);
        set_vec(18, "bfc_f1",   16'hC901, 5'b00100, O_NOTAKE, ST_FETCH);
        set_vec(19, "bnever",   16'hC400, 5'b11111, O_NOTAKE, ST_FETCH);

        // Reset state
        do_reset();
        check("reset_state", 16'(state), 16'(ST_FETCH));
        check("reset_outs",  16'(outs),  16'(O_IDLE));

        // Table: walk each instruction through every state it visits
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            instr = vecs[i].instr;
            flags = vecs[i].flags;
            #1;
            check({vecs[i].name, "_fetch"}, 16'(outs), 16'(O_IDLE));
            step();
            check({vecs[i].name, "_dec_st"}, 16'(state), 16'(ST_DECODE));
            check({vecs[i].name, "_dec"}, 16'(outs), 16'(O_DECODE));
            step();
            check({vecs[i].name, "_ex_st"}, 16'(state), 16'(ST_EXECUTE));
            check({vecs[i].name, "_ex"}, 16'(outs), 16'(vecs[i].exp_exec));
            step();
            check({vecs[i].name, "_next"}, 16'(state), 16'(vecs[i].exp_next));
            if (vecs[i].exp_next == ST_LOAD_WB) begin
                check({vecs[i].name, "_wb"}, 16'(outs), 16'(O_LOADWB));
                step();
                check({vecs[i].name, "_wb_next"}, 16'(state), 16'(ST_FETCH));
            end
        end

        // Stall held in FETCH for 5 cycles
        do_reset();
        instr = 16'h0152;
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_state", 16'(state), 16'(ST_FETCH));
            check("stall_outs",  16'(outs),  16'(O_IDLE));
        end
        stall = 1'b0;
        step();
        check("stall_release", 16'(state), 16'(ST_DECODE));

        // Stall raised during EXECUTE is ignored
        step();
        stall = 1'b1;
        #1;
        check("stall_ex_st",   16'(state), 16'(ST_EXECUTE));
        check("stall_ex_outs", 16'(outs),  16'(O_ALU));
        step();
        check("stall_ex_done", 16'(state), 16'(ST_FETCH));
        step();
        check("stall_ex_hold", 16'(state), 16'(ST_FETCH));
        stall = 1'b0;

        // Reset asserted during LOAD_WB aborts the write-back
        do_reset();
        instr = 16'h4203;
        step();
        step();
        step();
        check("rst_wb_state", 16'(state), 16'(ST_LOAD_WB));
        reset = 1'b1;
        #1;
        check("rst_wb_reg_we", 16'(reg_we), 16'(1'b0));
        check("rst_wb_outs",   16'(outs),   16'(O_IDLE));
        step();
        check("rst_wb_next",   16'(state),  16'(ST_FETCH));
        reset = 1'b0;
        #1;

        // HALT holds for 10 cycles until reset
        instr = 16'h40F0;
        step();
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            check("halt_state", 16'(state), 16'(ST_HALT));
            check("halt_outs",  16'(outs),  16'(O_HALT));
            step();
        end
        reset = 1'b1;
        #1;
        check("halt_rst_halted", 16'(halted), 16'(1'b0));
        step();
        reset = 1'b0;
        #1;
        check("halt_rst_state", 16'(state), 16'(ST_FETCH));
        check("halt_rst_outs",  16'(outs),  16'(O_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
